// File: rtl/tm1638_byte_phy.sv
// TM1638 byte engine: shifts one byte LSB-first on sclk/dio_out, or samples one byte from dio_in.
// STB is owned by the upstream sequencer; busy/done pace its steps.
module tm1638_byte_phy #(
    parameter int HALF_PERIOD = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       data_latch,
    input  logic       rw,
    input  logic [7:0] wr_data,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       done,
    output logic       sclk,
    output logic       dio_out,
    output logic       dio_oe,
    input  logic       dio_in,
    output logic [1:0] dbg_state
);

    // Handshake: data_latch is a valid strobe, !busy is ready; a transfer is
    // accepted on any edge where both are high, and done marks its completion.

    localparam int CW = $clog2(HALF_PERIOD + 1);
    localparam logic [CW-1:0] PH_LAST = CW'(HALF_PERIOD - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [CW-1:0]   r_phase;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
    logic            r_mode;
    logic            r_done;
    logic            r_oe;
    logic [7:0]      r_rd_data;
    logic            w_phase_end;
    logic            w_accept;
    logic            w_last;
    logic [7:0]      w_rx;

    always_comb begin
        w_phase_end  = (r_phase == PH_LAST);
        w_accept     = data_latch && (r_state == S_IDLE);
        w_last       = (r_state == S_HIGH) && w_phase_end && (r_bit == 3'd7);
        w_rx         = r_shift;
        w_rx[r_bit]  = dio_in;
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (data_latch) w_state_next = S_LOW;
            S_LOW:   if (w_phase_end) w_state_next = S_HIGH;
            S_HIGH:  if (w_phase_end) w_state_next = (r_bit == 3'd7) ? S_IDLE : S_LOW;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase   <= '0;
            r_bit     <= 3'd0;
            r_shift   <= 8'h00;
            r_mode    <= 1'b1;
            r_done    <= 1'b0;
            r_oe      <= 1'b1;
            r_rd_data <= 8'h00;
        end else begin
            r_done <= w_last;
            if (w_accept) begin
                r_shift <= wr_data;
                r_mode  <= rw;
                r_oe    <= rw;
                r_bit   <= 3'd0;
                r_phase <= '0;
            end else if (r_state != S_IDLE) begin
                if (w_phase_end) begin
                    r_phase <= '0;
                    if (r_state == S_HIGH) begin
                        // The TM1638 changes DIO on the falling edge, so the end of HIGH is the safe sample point.
                        r_shift <= r_mode ? (r_shift >> 1) : w_rx;
                        r_bit   <= r_bit + 3'd1;
                        if (w_last && !r_mode) r_rd_data <= w_rx;
                    end
                end else begin
                    r_phase <= r_phase + CW'(1);
                end
            end
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign sclk      = (r_state != S_LOW);
    assign dio_out   = (busy && r_mode) ? r_shift[0] : 1'b1;
    assign dio_oe    = r_oe;
    assign rd_data   = r_rd_data;
    assign dbg_state = r_state;

endmodule
